// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD shadow finder slice.
// Holds the transition-record layout, the default block parameters and
// the line FSM state encoding used by ccd_shadow_finder.
package ccd_pkg;

    // Transition record: {level, pixel index}
    localparam int IDX_W     = 11;
    localparam int LEVEL_BIT = IDX_W;
    localparam int IDX_HI    = IDX_W - 1;
    localparam int IDX_LO    = 0;
    localparam int REC_W     = IDX_W + 1;

    // Default block tuning
    localparam int MIN_WIDTH = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

endpackage

// File: rtl/ccd_segment_tracker.sv
// Best dark-segment tracker for one CCD line.
// Compares each presented segment against the stored best and replaces it
// when the segment is dark, in order, at least MIN_WIDTH wide and strictly
// wider than the current best (ties keep the earlier segment).
// Ports:
//   clk, rst            clock, async active-high reset
//   clear               drop the stored best (line end or abort)
//   update              a segment is presented this cycle
//   level               level of the presented segment (0 = dark)
//   seg_start, seg_end  presented segment bounds
//   next_start/end/width/found
//                       best segment including the presented one; lets the
//                       caller publish a line result in the same cycle as
//                       the final record
module ccd_segment_tracker #(
    parameter int IDX_W     = 11,
    parameter int MIN_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             update,
    input  logic             level,
    input  logic [IDX_W-1:0] seg_start,
    input  logic [IDX_W-1:0] seg_end,
    output logic [IDX_W-1:0] next_start,
    output logic [IDX_W-1:0] next_end,
    output logic [IDX_W-1:0] next_width,
    output logic             next_found
);

    localparam logic [IDX_W-1:0] MIN_W = IDX_W'(MIN_WIDTH);

    logic [IDX_W-1:0] best_start;
    logic [IDX_W-1:0] best_end;
    logic [IDX_W-1:0] best_w;
    logic             best_found;
    logic [IDX_W-1:0] seg_w;
    logic             replace;

    always_comb begin
        seg_w   = seg_end - seg_start;
        replace = update && !level && (seg_end >= seg_start)
                  && (seg_w >= MIN_W) && (seg_w > best_w);
        if (replace) begin
            next_start = seg_start;
            next_end   = seg_end;
            next_width = seg_w;
            next_found = 1'b1;
        end else begin
            next_start = best_start;
            next_end   = best_end;
            next_width = best_w;
            next_found = best_found;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_start <= '0;
            best_end   <= '0;
            best_w     <= '0;
            best_found <= 1'b0;
        end else if (clear) begin
            best_start <= '0;
            best_end   <= '0;
            best_w     <= '0;
            best_found <= 1'b0;
        end else if (replace) begin
            best_start <= seg_start;
            best_end   <= seg_end;
            best_w     <= seg_w;
            best_found <= 1'b1;
        end
    end

endmodule

// File: rtl/ccd_shadow_finder.sv
// CCD shadow finder: rebuilds line segments from the reader's transition
// records and publishes the widest qualifying dark segment at end of line.
// Ports:
//   clk, rst     clock, async active-high reset
//   enable       block enable; low aborts the current line
//   in_valid     transition record strobe
//   in_data      {level of ended segment, index where it ended}
//   in_last      final record of the line (qualifies in_valid)
//   res_valid    one-cycle pulse, result registers just updated
//   res_start/res_end/res_width/res_center
//                geometry of the best dark segment (0 when none)
//   res_found    a qualifying dark segment existed
//   res_edges    records in the line, saturating
//   res_error    an out-of-order index was seen
module ccd_shadow_finder #(
    parameter int IDX_W     = ccd_pkg::IDX_W,
    parameter int MIN_WIDTH = ccd_pkg::MIN_WIDTH,
    parameter int CNT_W     = ccd_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [IDX_W:0]   in_data,
    input  logic             in_last,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_start,
    output logic [IDX_W-1:0] res_end,
    output logic [IDX_W-1:0] res_width,
    output logic [IDX_W-1:0] res_center,
    output logic             res_found,
    output logic [CNT_W-1:0] res_edges,
    output logic             res_error
);

    import ccd_pkg::*;

    state_t state, state_next;

    logic [IDX_W-1:0] prev_idx;
    logic [CNT_W-1:0] edge_cnt;
    logic             line_error;

    logic             accept;
    logic             last_accept;
    logic             level;
    logic [IDX_W-1:0] seg_end;
    logic [CNT_W-1:0] edge_next;
    logic             error_next;
    logic [IDX_W-1:0] best_start;
    logic [IDX_W-1:0] best_end;
    logic [IDX_W-1:0] best_width;
    logic             best_found;
    logic [IDX_W:0]   center_sum;

    assign accept      = enable && in_valid;
    assign last_accept = accept && in_last;
    assign level       = in_data[IDX_W];
    assign seg_end     = in_data[IDX_W-1:0];
    assign edge_next   = (edge_cnt == '1) ? edge_cnt : edge_cnt + 1'b1;
    assign error_next  = line_error || (seg_end < prev_idx);
    // Extra bit keeps the sum exact at the top of the index range.
    assign center_sum  = {1'b0, best_start} + {1'b0, best_end};

    ccd_segment_tracker #(
        .IDX_W     (IDX_W),
        .MIN_WIDTH (MIN_WIDTH)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clear      (!enable || last_accept),
        .update     (accept),
        .level      (level),
        .seg_start  (prev_idx),
        .seg_end    (seg_end),
        .next_start (best_start),
        .next_end   (best_end),
        .next_width (best_width),
        .next_found (best_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A record arriving in REPORT starts the next line; accumulators were
    // already cleared when the result loaded, so prev_idx is 0 there.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else if (in_valid) begin
            state_next = in_last ? ST_REPORT : ST_COLLECT;
        end else if (state == ST_REPORT) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_idx   <= '0;
            edge_cnt   <= '0;
            line_error <= 1'b0;
        end else if (!enable || last_accept) begin
            prev_idx   <= '0;
            edge_cnt   <= '0;
            line_error <= 1'b0;
        end else if (accept) begin
            prev_idx   <= seg_end;
            edge_cnt   <= edge_next;
            line_error <= error_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_start  <= '0;
            res_end    <= '0;
            res_width  <= '0;
            res_center <= '0;
            res_found  <= 1'b0;
            res_edges  <= '0;
            res_error  <= 1'b0;
        end else if (last_accept) begin
            res_start  <= best_start;
            res_end    <= best_end;
            res_width  <= best_width;
            res_center <= center_sum[IDX_W:1];
            res_found  <= best_found;
            res_edges  <= edge_next;
            res_error  <= error_next;
        end
    end

    assign res_valid = (state == ST_REPORT);

endmodule
